decode_stage: RTL and testbench
===============================

# decode_stage

Instruction decode stage for the RV32I core, sitting directly upstream of the ALU. It accepts a fetched instruction word and PC over a valid/ready handshake, reads source operands from an internal 32×32 register file, and maps the instruction to an ALU operation. It then presents the ALU operation and both final operands in a registered output slot for the execute stage. This revision decodes ALU-class instructions only; all other encodings are flagged illegal.

## Interface
Parameters:
- none (widths come from the `definitions` package: `t_data` = 32 bits, `t_reg_index` = 5 bits)

Ports:
- Clock and reset: one clock; reset is synchronous and active-low.
- `i_clk`  input  1  clock; all state updates on the rising edge
- `i_rst_n`  input  1  synchronous active-low reset
- `i_valid`  input  1  upstream instruction valid
- `o_ready`  output  1  decode can accept this cycle
- `i_instruction`  input  32  RV32I instruction word
- `i_pc`  input  `t_data`  PC of `i_instruction`
- `i_flush`  input  1  discard output slot and any same-cycle input
- `i_wb_enable`  input  1  register file write strobe
- `i_wb_rd`  input  `t_reg_index`  write destination
- `i_wb_data`  input  `t_data`  write value
- `o_valid`  output  1  output slot holds a decoded instruction
- `i_ready`  input  1  execute stage consumes the slot
- `o_operation`  output  `t_alu_operation`  ALU operation
- `o_operand1`  output  `t_data`  ALU operand 1
- `o_operand2`  output  `t_data`  ALU operand 2
- `o_rd`  output  `t_reg_index`  destination register
- `o_rd_write`  output  1  result must be written back
- `o_illegal`  output  1  encoding not supported

## Operation
- `o_ready = !o_valid || i_ready`; this is combinational.
- Accept: `i_valid && o_ready && !i_flush`. The slot loads decoded fields and sets `o_valid` on the same edge.
- The slot clears when `o_valid && i_ready` with no accept, or when `i_flush` is high. Flush wins over accept. A transfer coinciding with flush counts as taken upstream and is dropped.
- The slot stays stable while `o_valid && !i_ready`.
- Decode rules:
  - OP (0110011): ADD/SUB/SLL/XOR/SRL/SRA/OR/AND. Operands are rs1, rs2.
  - OP-IMM (0010011): ADDI/XORI/ORI/ANDI/SLLI/SRLI/SRAI. Operands are rs1 and the sign-extended I-immediate.
  - LUI: operation ADD, operands 0 and `{imm[31:12],12'b0}`.
  - AUIPC: operation ADD, operands `i_pc` and the U-immediate.
- Shifts: operand2 = `{27'b0, amount[4:0]}`, where the amount is rs2 value or shamt. The ALU shifts by the full operand, so this masking is mandatory.
- Illegal encodings:
  - SLT/SLTU/SLTI/SLTIU
  - any other opcode
  - funct7 ∉ {0000000, 0100000}, or 0100000 with a funct3 other than ADD/SRL
  - For all of these: the slot is still valid with `o_illegal=1`, operation ADD, operands 0, `o_rd_write=0`.
- `o_rd_write = !illegal && rd != 0`.
- Register file:
  - x0 reads 0; writes to x0 are ignored.
  - Operands are captured at accept. RAW hazards against in-flight older instructions are handled by upstream stall logic, not here.

## Timing
- Latency: 1 cycle from accept to `o_valid`. Throughput is 1 instruction/cycle while `i_ready=1`.
- Reset: `o_valid=0`, `o_ready=1`, `o_operation=ALU_OP_ADD`, operands 0, `o_rd=0`, `o_rd_write=0`, `o_illegal=0`. All 32 registers are cleared.
- Register write takes effect at the edge. A write and a read of the same register in one cycle are governed by Configuration.
- Reset mid-operation discards the slot. There are no pending writes.

## Configuration
- `DECODE_STAGE_BYPASS_EN` defined: a same-cycle `i_wb_enable` write to rs1/rs2 (non-zero index) is forwarded into the captured operand.
- Not defined: the read returns the pre-write value, and the new value is visible from the next cycle.

## Structure
- The `definitions` package gains:
  - `t_reg_index`
  - `t_instruction`
  - `t_opcode` enum (OPCODE_OP, OPCODE_OP_IMM, OPCODE_LUI, OPCODE_AUIPC)
  - funct3/funct7 constants
- Sub-module `register_file`: 2 combinational read ports, 1 synchronous write port, synchronous active-low reset, with the bypass under the macro.

## Test plan
- Reset, then ADDI x1,x0,5 (0x00500093) with `i_ready=1` → next cycle `o_valid=1`, ADD, 0, 5, `o_rd=1`, `o_rd_write=1`.
- Write x2=0xFFFFFFF0, then SRAI x3,x2,4 (0x40415193) → SHIFT_RIGHT_ARITH, 0xFFFFFFF0, 4.
- AUIPC x4,1 (0x00001217) at PC 0x100 → ADD, 0x100, 0x1000. Hold `i_ready=0` for 3 cycles → outputs stable, `o_ready=0`, next instruction not taken.
- Same cycle: write x5=0x1234 and decode ADD x6,x5,x0 (0x00028333) → operand1=0x1234 with the macro, 0 without.
- SLTI (0x00102093) and ECALL (0x00000073) → `o_illegal=1`, `o_rd_write=0`, operands 0.
- Flush with `o_valid=1` and `i_valid=1` → next cycle `o_valid=0`. Write x0=7, then ADD x6,x0,x0 → operand1=0.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared types for the RV32I decode stage: data/index widths, opcodes, ALU operations, funct codes.
// Imported by the decode top, its register file and its handshake interface.
package decode_stage_pkg;

    typedef logic [31:0] t_data;
    typedef logic [4:0]  t_reg_index;
    typedef logic [31:0] t_instruction;

    typedef enum logic [6:0] {
        OPCODE_OP     = 7'b0110011,
        OPCODE_OP_IMM = 7'b0010011,
        OPCODE_LUI    = 7'b0110111,
        OPCODE_AUIPC  = 7'b0010111
    } t_opcode;

    typedef enum logic [3:0] {
        ALU_OP_ADD,
        ALU_OP_SUB,
        ALU_OP_SHIFT_LEFT,
        ALU_OP_XOR,
        ALU_OP_SHIFT_RIGHT_LOGIC,
        ALU_OP_SHIFT_RIGHT_ARITH,
        ALU_OP_OR,
        ALU_OP_AND
    } t_alu_operation;

    localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
    localparam logic [2:0] FUNCT3_SLL     = 3'b001;
    localparam logic [2:0] FUNCT3_SLT     = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
    localparam logic [2:0] FUNCT3_XOR     = 3'b100;
    localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
    localparam logic [2:0] FUNCT3_OR      = 3'b110;
    localparam logic [2:0] FUNCT3_AND     = 3'b111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    // The ALU shifts by its whole operand, so the amount must be cut to 5 bits here.
    function automatic t_data shift_amount(input t_data value);
        return {27'b0, value[4:0]};
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Handshake and data bundle between fetch, writeback and the decode stage.
// master drives instructions/writebacks and consumes the slot; slave is the decode stage.
interface decode_stage_if;
    import decode_stage_pkg::*;

    logic           i_valid;
    logic           o_ready;
    t_instruction   i_instruction;
    t_data          i_pc;
    logic           i_flush;
    logic           i_wb_enable;
    t_reg_index     i_wb_rd;
    t_data          i_wb_data;
    logic           o_valid;
    logic           i_ready;
    t_alu_operation o_operation;
    t_data          o_operand1;
    t_data          o_operand2;
    t_reg_index     o_rd;
    logic           o_rd_write;
    logic           o_illegal;

    modport master (
        output i_valid, i_instruction, i_pc, i_flush, i_wb_enable, i_wb_rd, i_wb_data, i_ready,
        input  o_ready, o_valid, o_operation, o_operand1, o_operand2, o_rd, o_rd_write, o_illegal
    );

    modport slave (
        input  i_valid, i_instruction, i_pc, i_flush, i_wb_enable, i_wb_rd, i_wb_data, i_ready,
        output o_ready, o_valid, o_operation, o_operand1, o_operand2, o_rd, o_rd_write, o_illegal
    );
endinterface

// File: rtl/decode_stage_register_file.sv
// 32x32 register file: two combinational reads, one synchronous write, x0 hardwired to zero.
// DECODE_STAGE_BYPASS_EN forwards a same-cycle write into the read ports.
module register_file
    import decode_stage_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  t_reg_index rs1,
    input  t_reg_index rs2,
    output t_data      rs1_data,
    output t_data      rs2_data,
    input  logic       wb_enable,
    input  t_reg_index wb_rd,
    input  t_data      wb_data
);

    t_data regs [32];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_enable && wb_rd != '0) begin
            regs[wb_rd] <= wb_data;
        end
    end

`ifdef DECODE_STAGE_BYPASS_EN
    always_comb begin
        rs1_data = (rs1 == '0) ? '0 : regs[rs1];
        rs2_data = (rs2 == '0) ? '0 : regs[rs2];
        if (wb_enable && wb_rd != '0 && wb_rd == rs1) rs1_data = wb_data;
        if (wb_enable && wb_rd != '0 && wb_rd == rs2) rs2_data = wb_data;
    end
`else
    assign rs1_data = (rs1 == '0) ? '0 : regs[rs1];
    assign rs2_data = (rs2 == '0) ? '0 : regs[rs2];
`endif

endmodule

// File: rtl/decode_stage.sv
// RV32I ALU-class decode into a registered slot; optional DECODE_STAGE_BYPASS_EN write forwarding.
// Latency 1 cycle accept->o_valid; o_ready = !o_valid || i_ready, slot holds while stalled.
// Flush drops the slot and any same-cycle input; unsupported encodings yield a valid illegal slot.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    decode_stage_if.slave bus
);

    t_instruction   instr;
    logic [6:0]     opcode;
    logic [2:0]     funct3;
    logic [6:0]     funct7;
    t_reg_index     rs1, rs2, rd;
    t_data          rs1_data, rs2_data;
    t_data          imm_i, imm_u;
    t_alu_operation dec_op;
    t_data          dec_src1, dec_src2;
    logic           dec_illegal, is_shift, alt, accept;

    assign instr  = bus.i_instruction;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_u  = {instr[31:12], 12'b0};

    register_file u_register_file (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .rs1       (rs1),
        .rs2       (rs2),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .wb_enable (bus.i_wb_enable),
        .wb_rd     (bus.i_wb_rd),
        .wb_data   (bus.i_wb_data)
    );

    function automatic t_alu_operation alu_op(input logic [2:0] f3, input logic use_alt);
        case (f3)
            FUNCT3_ADD_SUB: return use_alt ? ALU_OP_SUB : ALU_OP_ADD;
            FUNCT3_SLL:     return ALU_OP_SHIFT_LEFT;
            FUNCT3_XOR:     return ALU_OP_XOR;
            FUNCT3_SRL_SRA: return use_alt ? ALU_OP_SHIFT_RIGHT_ARITH : ALU_OP_SHIFT_RIGHT_LOGIC;
            FUNCT3_OR:      return ALU_OP_OR;
            FUNCT3_AND:     return ALU_OP_AND;
            default:        return ALU_OP_ADD;
        endcase
    endfunction

    assign is_shift = (funct3 == FUNCT3_SLL) || (funct3 == FUNCT3_SRL_SRA);
    assign alt      = (funct7 == FUNCT7_ALT);

    always_comb begin
        dec_op      = ALU_OP_ADD;
        dec_src1    = '0;
        dec_src2    = '0;
        dec_illegal = 1'b0;
        case (opcode)
            OPCODE_OP: begin
                dec_op   = alu_op(funct3, alt);
                dec_src1 = rs1_data;
                dec_src2 = is_shift ? shift_amount(rs2_data) : rs2_data;
                if (funct3 == FUNCT3_SLT || funct3 == FUNCT3_SLTU) dec_illegal = 1'b1;
                if (!(funct7 == FUNCT7_BASE ||
                      (alt && (funct3 == FUNCT3_ADD_SUB || funct3 == FUNCT3_SRL_SRA))))
                    dec_illegal = 1'b1;
            end
            OPCODE_OP_IMM: begin
                // funct7 only exists as a field for the immediate shifts.
                dec_op   = alu_op(funct3, alt && funct3 == FUNCT3_SRL_SRA);
                dec_src1 = rs1_data;
                dec_src2 = is_shift ? shift_amount(imm_i) : imm_i;
                if (funct3 == FUNCT3_SLT || funct3 == FUNCT3_SLTU) dec_illegal = 1'b1;
                if (is_shift && !(funct7 == FUNCT7_BASE || (alt && funct3 == FUNCT3_SRL_SRA)))
                    dec_illegal = 1'b1;
            end
            OPCODE_LUI: begin
                dec_src2 = imm_u;
            end
            OPCODE_AUIPC: begin
                dec_src1 = bus.i_pc;
                dec_src2 = imm_u;
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_op   = ALU_OP_ADD;
            dec_src1 = '0;
            dec_src2 = '0;
        end
    end

    assign bus.o_ready = !bus.o_valid || bus.i_ready;
    assign accept      = bus.i_valid && bus.o_ready && !bus.i_flush;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            bus.o_valid     <= 1'b0;
            bus.o_operation <= ALU_OP_ADD;
            bus.o_operand1  <= '0;
            bus.o_operand2  <= '0;
            bus.o_rd        <= '0;
            bus.o_rd_write  <= 1'b0;
            bus.o_illegal   <= 1'b0;
        end else if (bus.i_flush) begin
            bus.o_valid <= 1'b0;
        end else if (accept) begin
            bus.o_valid     <= 1'b1;
            bus.o_operation <= dec_op;
            bus.o_operand1  <= dec_src1;
            bus.o_operand2  <= dec_src2;
            bus.o_rd        <= rd;
            bus.o_rd_write  <= !dec_illegal && rd != '0;
            bus.o_illegal   <= dec_illegal;
        end else if (bus.o_valid && bus.i_ready) begin
            bus.o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a vector table of single instructions plus hand sequences
// for stall, same-cycle writeback, flush, x0 writes and mid-operation reset.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    decode_stage_if bus ();

    decode_stage dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave)
    );

    typedef struct {
        logic [31:0]    instr;
        logic [31:0]    pc;
        t_alu_operation op;
        logic [31:0]    op1;
        logic [31:0]    op2;
        logic [4:0]     rd;
        logic           rd_write;
        logic           illegal;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
        bus.i_wb_enable = 1'b1;
        bus.i_wb_rd     = r;
        bus.i_wb_data   = d;
        step();
        bus.i_wb_enable = 1'b0;
    endtask

    task automatic idle();
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        step();
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input logic rdy);
        bus.i_valid       = 1'b1;
        bus.i_instruction = ins;
        bus.i_pc          = pc;
        bus.i_ready       = rdy;
        step();
        bus.i_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_bypass;
`ifdef DECODE_STAGE_BYPASS_EN
        exp_bypass = 32'h0000_1234;
`else
        exp_bypass = 32'h0;
`endif
        vecs[0]  = '{32'h00500093, 32'h0,   ALU_OP_ADD,               32'h0,        32'h5,        5'd1,  1'b1, 1'b0};
        vecs[1]  = '{32'h40415193, 32'h0,   ALU_OP_SHIFT_RIGHT_ARITH, 32'hFFFFFFF0, 32'h4,        5'd3,  1'b1, 1'b0};
        vecs[2]  = '{32'h00001217, 32'h100, ALU_OP_ADD,               32'h100,      32'h1000,     5'd4,  1'b1, 1'b0};
        vecs[3]  = '{32'h00102093, 32'h0,   ALU_OP_ADD,               32'h0,        32'h0,        5'd1,  1'b0, 1'b1};
        vecs[4]  = '{32'h00000073, 32'h0,   ALU_OP_ADD,               32'h0,        32'h0,        5'd0,  1'b0, 1'b1};
        vecs[5]  = '{32'hABCDE537, 32'h0,   ALU_OP_ADD,               32'h0,        32'hABCDE000, 5'd10, 1'b1, 1'b0};
        vecs[6]  = '{32'h402485B3, 32'h0,   ALU_OP_SUB,               32'h80000001, 32'hFFFFFFF0, 5'd11, 1'b1, 1'b0};
        vecs[7]  = '{32'h00749433, 32'h0,   ALU_OP_SHIFT_LEFT,        32'h80000001, 32'h5,        5'd8,  1'b1, 1'b0};
        vecs[8]  = '{32'h02248633, 32'h0,   ALU_OP_ADD,               32'h0,        32'h0,        5'd12, 1'b0, 1'b1};
        vecs[9]  = '{32'h4024C6B3, 32'h0,   ALU_OP_ADD,               32'h0,        32'h0,        5'd13, 1'b0, 1'b1};
        vecs[10] = '{32'hFFF4F713, 32'h0,   ALU_OP_AND,               32'h80000001, 32'hFFFFFFFF, 5'd14, 1'b1, 1'b0};
        vecs[11] = '{32'h0024E033, 32'h0,   ALU_OP_OR,                32'h80000001, 32'hFFFFFFF0, 5'd0,  1'b0, 1'b0};
        vecs[12] = '{32'h007157B3, 32'h0,   ALU_OP_SHIFT_RIGHT_LOGIC, 32'hFFFFFFF0, 32'h5,        5'd15, 1'b1, 1'b0};
        vecs[13] = '{32'h0024B833, 32'h0,   ALU_OP_ADD,               32'h0,        32'h0,        5'd16, 1'b0, 1'b1};

        rst_n             = 1'b0;
        bus.i_valid       = 1'b0;
        bus.i_instruction = '0;
        bus.i_pc          = '0;
        bus.i_flush       = 1'b0;
        bus.i_wb_enable   = 1'b0;
        bus.i_wb_rd       = '0;
        bus.i_wb_data     = '0;
        bus.i_ready       = 1'b0;
        step();
        step();
        check("rst o_valid",    32'(bus.o_valid),     32'd0);
        check("rst o_ready",    32'(bus.o_ready),     32'd1);
        check("rst o_operation",32'(bus.o_operation), 32'(ALU_OP_ADD));
        check("rst o_operand1", bus.o_operand1,       32'd0);
        check("rst o_operand2", bus.o_operand2,       32'd0);
        check("rst o_rd",       32'(bus.o_rd),        32'd0);
        check("rst o_rd_write", 32'(bus.o_rd_write),  32'd0);
        check("rst o_illegal",  32'(bus.o_illegal),   32'd0);
        rst_n = 1'b1;

        wb_write(5'd2, 32'hFFFFFFF0);
        wb_write(5'd7, 32'h00000025);
        wb_write(5'd9, 32'h80000001);

        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].instr, vecs[i].pc, 1'b1);
            check($sformatf("v%0d valid", i),    32'(bus.o_valid),     32'd1);
            check($sformatf("v%0d op", i),       32'(bus.o_operation), 32'(vecs[i].op));
            check($sformatf("v%0d op1", i),      bus.o_operand1,       vecs[i].op1);
            check($sformatf("v%0d op2", i),      bus.o_operand2,       vecs[i].op2);
            check($sformatf("v%0d rd", i),       32'(bus.o_rd),        32'(vecs[i].rd));
            check($sformatf("v%0d rd_write", i), 32'(bus.o_rd_write),  32'(vecs[i].rd_write));
            check($sformatf("v%0d illegal", i),  32'(bus.o_illegal),   32'(vecs[i].illegal));
        end

        // Stall: slot holds AUIPC, a following ADDI must not be taken.
        idle();
        check("drain valid", 32'(bus.o_valid), 32'd0);
        issue(32'h00001217, 32'h100, 1'b0);
        check("stall load valid", 32'(bus.o_valid), 32'd1);
        for (int c = 0; c < 3; c++) begin
            bus.i_valid       = 1'b1;
            bus.i_instruction = 32'h00500093;
            bus.i_pc          = 32'h104;
            bus.i_ready       = 1'b0;
            #1;
            check($sformatf("stall%0d o_ready", c), 32'(bus.o_ready), 32'd0);
            step();
            check($sformatf("stall%0d valid", c), 32'(bus.o_valid),    32'd1);
            check($sformatf("stall%0d op1", c),   bus.o_operand1,      32'h100);
            check($sformatf("stall%0d op2", c),   bus.o_operand2,      32'h1000);
            check($sformatf("stall%0d rd", c),    32'(bus.o_rd),       32'd4);
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        #1;
        check("unstall o_ready", 32'(bus.o_ready), 32'd1);
        step();
        check("stalled ADDI not taken", 32'(bus.o_valid), 32'd0);

        // Same-cycle writeback and read of x5.
        bus.i_wb_enable = 1'b1;
        bus.i_wb_rd     = 5'd5;
        bus.i_wb_data   = 32'h1234;
        issue(32'h00028333, 32'h0, 1'b1);
        bus.i_wb_enable = 1'b0;
        check("same-cycle wb op1", bus.o_operand1, exp_bypass);
        issue(32'h00028333, 32'h0, 1'b1);
        check("next-cycle wb op1", bus.o_operand1, 32'h1234);

        // Flush with a valid slot and a same-cycle input.
        idle();
        issue(32'h00500093, 32'h0, 1'b0);
        check("pre-flush valid", 32'(bus.o_valid), 32'd1);
        bus.i_flush = 1'b1;
        issue(32'h00028333, 32'h0, 1'b0);
        bus.i_flush = 1'b0;
        check("flush clears slot", 32'(bus.o_valid), 32'd0);
        step();
        check("flushed input dropped", 32'(bus.o_valid), 32'd0);

        // Writes to x0 are ignored.
        wb_write(5'd0, 32'h7);
        issue(32'h00000333, 32'h0, 1'b1);
        check("x0 op1", bus.o_operand1, 32'd0);
        check("x0 op2", bus.o_operand2, 32'd0);
        check("x0 rd_write", 32'(bus.o_rd_write), 32'd1);

        // Reset mid-operation discards the slot and clears registers.
        idle();
        issue(32'h00500093, 32'h0, 1'b0);
        rst_n = 1'b0;
        step();
        check("midrst valid", 32'(bus.o_valid), 32'd0);
        check("midrst rd",    32'(bus.o_rd),    32'd0);
        rst_n = 1'b1;
        issue(32'h00028333, 32'h0, 1'b1);
        check("post-rst x5 cleared", bus.o_operand1, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
